// File: rtl/wb_arbiter_if.sv
// Result-channel bundle between the functional units and the write-back arbiter.
// The units drive valid/data/destination; the arbiter answers with a per-channel accept.
interface wb_arbiter_if #(
  parameter int NCH  = 3,
  parameter int XLEN = 32,
  parameter int RDW  = 5
);
  logic [NCH-1:0]      res_v_i;
  logic [NCH*XLEN-1:0] res_i;
  logic [NCH*RDW-1:0]  rd_i;
  logic [NCH-1:0]      ok_o;

  modport master (output res_v_i, res_i, rd_i, input ok_o);
  modport slave  (input res_v_i, res_i, rd_i, output ok_o);
endinterface

// File: rtl/wb_arbiter.sv
// N-channel write-back arbiter: one-entry buffer per channel, round-robin with an
// optional starvation-limited priority channel, and a single registered write port.
module wb_arbiter #(
  parameter int NCH          = 3,
  parameter int XLEN         = 32,
  parameter int RDW          = 5,
  parameter int PRIO_EN      = 1,
  parameter int PRIO_CH      = 1,
  parameter int MAX_PRIO_RUN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_arbiter_if.slave      ch,
  input  logic             flush,
  output logic [XLEN-1:0]  result,
  output logic [RDW-1:0]   rd,
  output logic             result_v,
  output logic [15:0]      conflict_cnt
);

  localparam int PTRW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PRW  = (MAX_PRIO_RUN > 0) ? $clog2(MAX_PRIO_RUN + 1) : 1;

  logic [NCH-1:0]  buf_v_q, buf_v_d;
  logic [XLEN-1:0] buf_data_q [NCH];
  logic [RDW-1:0]  buf_rd_q   [NCH];
  logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PRW-1:0]  prio_run_q, prio_run_d;
  logic [15:0]     conflict_q, conflict_d;
  logic [XLEN-1:0] result_q;
  logic [RDW-1:0]  rd_q;
  logic            result_v_q;

  logic [NCH-1:0]  grant, ok, accept;
  logic [PTRW-1:0] win;
  logic            any_grant, prio_hit, others_pend;
  int              idx;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    grant       = '0;
    win         = '0;
    any_grant   = 1'b0;
    idx         = 0;
    others_pend = |(buf_v_q & ~(NCH'(1) << PRIO_CH));
    prio_hit    = (PRIO_EN != 0) && buf_v_q[PRIO_CH] &&
                  (prio_run_q < PRW'(MAX_PRIO_RUN));
    if (prio_hit) begin
      grant[PRIO_CH] = 1'b1;
      win            = PTRW'(PRIO_CH);
      any_grant      = 1'b1;
    end else begin
      // First pending channel at or above rr_ptr, wrapping modulo NCH.
      for (int k = 0; k < NCH; k++) begin
        idx = (int'(rr_ptr_q) + k) % NCH;
        if (!any_grant && buf_v_q[idx]) begin
          grant[idx] = 1'b1;
          win        = PTRW'(idx);
          any_grant  = 1'b1;
        end
      end
    end
  end

  // A granted buffer frees this cycle, so it may refill at the same edge.
  assign ok       = flush ? '0 : (~buf_v_q | grant);
  assign ch.ok_o  = ok;
  assign accept   = ch.res_v_i & ok;

  always_comb begin
    buf_v_d    = flush ? '0 : ((buf_v_q & ~grant) | accept);
    rr_ptr_d   = rr_ptr_q;
    prio_run_d = prio_run_q;
    conflict_d = ($countones(buf_v_q) >= 2) ? sat_inc16(conflict_q) : conflict_q;
    if (!flush) begin
      if (prio_hit) begin
        prio_run_d = others_pend ? prio_run_q + PRW'(1) : '0;
      end else begin
        prio_run_d = '0;
        if (any_grant) rr_ptr_d = PTRW'((int'(win) + 1) % NCH);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      buf_v_q    <= '0;
      rr_ptr_q   <= '0;
      prio_run_q <= '0;
      conflict_q <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      result_v_q <= 1'b0;
    end else begin
      buf_v_q    <= buf_v_d;
      rr_ptr_q   <= rr_ptr_d;
      prio_run_q <= prio_run_d;
      conflict_q <= conflict_d;
      if (!flush && any_grant) begin
        result_q   <= buf_data_q[win];
        rd_q       <= buf_rd_q[win];
        // Writes to x0 still consume the grant but never reach the register file.
        result_v_q <= (buf_rd_q[win] != '0);
      end else begin
        result_v_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept[i]) begin
        buf_data_q[i] <= ch.res_i[i*XLEN +: XLEN];
        buf_rd_q[i]   <= ch.rd_i[i*RDW +: RDW];
      end
    end
  end

  assign result       = result_q;
  assign rd           = rd_q;
  assign result_v     = result_v_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the arbitration rules, on a priority and a pure round-robin instance.
module tb_wb_arbiter;
  localparam int NCH  = 3;
  localparam int XLEN = 32;
  localparam int RDW  = 5;
  localparam int PCH  = 1;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]      res_v;
  logic [NCH*XLEN-1:0] res;
  logic [NCH*RDW-1:0]  rdi;
  logic                flush;

  logic [XLEN-1:0] res_p, res_r;
  logic [RDW-1:0]  rd_p, rd_r;
  logic            rv_p, rv_r;
  logic [15:0]     cc_p, cc_r;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter_if #(.NCH(NCH), .XLEN(XLEN), .RDW(RDW)) if_p ();
  wb_arbiter_if #(.NCH(NCH), .XLEN(XLEN), .RDW(RDW)) if_r ();

  assign if_p.res_v_i = res_v;
  assign if_p.res_i   = res;
  assign if_p.rd_i    = rdi;
  assign if_r.res_v_i = res_v;
  assign if_r.res_i   = res;
  assign if_r.rd_i    = rdi;

  wb_arbiter #(.NCH(NCH), .XLEN(XLEN), .RDW(RDW), .PRIO_EN(1), .PRIO_CH(PCH),
               .MAX_PRIO_RUN(MAXR)) dut_p (
    .clk(clk), .rst_n(rst_n), .ch(if_p), .flush(flush),
    .result(res_p), .rd(rd_p), .result_v(rv_p), .conflict_cnt(cc_p));

  wb_arbiter #(.NCH(NCH), .XLEN(XLEN), .RDW(RDW), .PRIO_EN(0), .PRIO_CH(PCH),
               .MAX_PRIO_RUN(MAXR)) dut_r (
    .clk(clk), .rst_n(rst_n), .ch(if_r), .flush(flush),
    .result(res_r), .rd(rd_r), .result_v(rv_r), .conflict_cnt(cc_r));

  // Reference model state; index 0 = priority instance, 1 = round-robin instance.
  bit              m_bv  [2][NCH];
  logic [XLEN-1:0] m_bd  [2][NCH];
  logic [RDW-1:0]  m_br  [2][NCH];
  int              m_rr  [2];
  int              m_pr  [2];
  int              m_cc  [2];
  bit              m_rv  [2];
  logic [XLEN-1:0] m_res [2];
  logic [RDW-1:0]  m_rd  [2];

  task automatic idle_inputs();
    res_v = '0; res = '0; rdi = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic set_ch(input int i, input logic [XLEN-1:0] d, input logic [RDW-1:0] r);
    res_v[i] = 1'b1;
    res[i*XLEN +: XLEN] = d;
    rdi[i*RDW +: RDW] = r;
  endtask

  function automatic int model_pick(input int n, output bit by_prio);
    by_prio = 1'b0;
    if (n == 0 && m_bv[n][PCH] && m_pr[n] < MAXR) begin
      by_prio = 1'b1;
      return PCH;
    end
    for (int k = 0; k < NCH; k++)
      if (m_bv[n][(m_rr[n] + k) % NCH]) return (m_rr[n] + k) % NCH;
    return -1;
  endfunction

  task automatic model_step(input int n, input int w, input bit bp, input logic [NCH-1:0] okv);
    int pend;
    bit others;
    pend = 0;
    others = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      pend += int'(m_bv[n][i]);
      if (i != PCH && m_bv[n][i]) others = 1'b1;
    end
    if (pend >= 2 && m_cc[n] < 65535) m_cc[n]++;
    if (flush) begin
      for (int i = 0; i < NCH; i++) m_bv[n][i] = 1'b0;
      m_rv[n] = 1'b0;
    end else begin
      if (w >= 0) begin
        m_res[n] = m_bd[n][w];
        m_rd[n]  = m_br[n][w];
        m_rv[n]  = (m_br[n][w] != 0);
        if (bp) m_pr[n] = others ? m_pr[n] + 1 : 0;
        else begin
          m_pr[n] = 0;
          m_rr[n] = (w + 1) % NCH;
        end
      end else begin
        m_rv[n] = 1'b0;
        m_pr[n] = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        if (res_v[i] && okv[i]) begin
          m_bv[n][i] = 1'b1;
          m_bd[n][i] = res[i*XLEN +: XLEN];
          m_br[n][i] = rdi[i*RDW +: RDW];
        end else if (w == i) begin
          m_bv[n][i] = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b1;
    #2;
    n_checks++; if (if_p.ok_o !== 3'b111) begin n_fail++; $display("FAIL reset_ok: got %b expected 111", if_p.ok_o); end
    n_checks++; if (rv_p !== 1'b0) begin n_fail++; $display("FAIL reset_result_v: got %b expected 0", rv_p); end
    n_checks++; if (res_p !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", res_p); end
    n_checks++; if (rd_p !== '0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", rd_p); end
    n_checks++; if (cc_p !== 16'd0) begin n_fail++; $display("FAIL reset_conflict: got %0d expected 0", cc_p); end
    n_checks++; if (if_r.ok_o !== 3'b111 || rv_r !== 1'b0) begin n_fail++; $display("FAIL reset_rr: ok %b rv %b expected 111 0", if_r.ok_o, rv_r); end
  endtask

  task automatic test_single();
    do_reset();
    set_ch(0, 32'hDEADBEEF, 5'd7);
    n_checks++; if (if_p.ok_o[0] !== 1'b1) begin n_fail++; $display("FAIL single_ok_c1: got %b expected 1", if_p.ok_o[0]); end
    tick();
    res_v = '0;
    n_checks++; if (rv_p !== 1'b0) begin n_fail++; $display("FAIL single_rv_c2: got %b expected 0", rv_p); end
    n_checks++; if (if_p.ok_o[0] !== 1'b1) begin n_fail++; $display("FAIL single_ok_c2: got %b expected 1", if_p.ok_o[0]); end
    tick();
    n_checks++; if (rv_p !== 1'b1) begin n_fail++; $display("FAIL single_rv_c3: got %b expected 1", rv_p); end
    n_checks++; if (res_p !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef", res_p); end
    n_checks++; if (rd_p !== 5'd7) begin n_fail++; $display("FAIL single_rd: got %0d expected 7", rd_p); end
    tick();
    n_checks++; if (rv_p !== 1'b0) begin n_fail++; $display("FAIL single_rv_c4: got %b expected 0", rv_p); end
  endtask

  task automatic test_collision();
    do_reset();
    for (int i = 0; i < NCH; i++) set_ch(i, 32'hA0000000 + XLEN'(i), RDW'(i + 1));
    tick();
    res_v = '0;
    tick();
    for (int c = 0; c < NCH; c++) begin
      n_checks++; if (rv_r !== 1'b1 || res_r !== 32'hA0000000 + XLEN'(c) || rd_r !== RDW'(c + 1)) begin
        n_fail++; $display("FAIL collision_out%0d: got v=%b d=%h rd=%0d expected v=1 d=%h rd=%0d",
                            c, rv_r, res_r, rd_r, 32'hA0000000 + c, c + 1);
      end
      tick();
    end
    n_checks++; if (rv_r !== 1'b0) begin n_fail++; $display("FAIL collision_idle: got %b expected 0", rv_r); end
    n_checks++; if (cc_r !== 16'd2) begin n_fail++; $display("FAIL collision_conflict: got %0d expected 2", cc_r); end
    n_checks++; if (dut_r.rr_ptr_q !== '0) begin n_fail++; $display("FAIL collision_rr_ptr: got %0d expected 0", dut_r.rr_ptr_q); end
  endtask

  task automatic test_priority();
    int seq;
    bit acc;
    logic [XLEN-1:0] ed;
    logic [RDW-1:0]  er;
    seq = 0;
    do_reset();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc >= 3) begin
        if (cyc == 7) begin ed = 32'h0C0; er = 5'd4; end
        else if (cyc == 8) begin ed = 32'h104; er = 5'd9; end
        else begin ed = 32'h100 + XLEN'(cyc - 3); er = 5'd9; end
        n_checks++; if (rv_p !== 1'b1 || res_p !== ed || rd_p !== er) begin
          n_fail++; $display("FAIL prio_slot%0d: got v=%b d=%h rd=%0d expected v=1 d=%h rd=%0d",
                              cyc, rv_p, res_p, rd_p, ed, er);
        end
      end
      if (cyc == 4) begin
        n_checks++; if (if_p.ok_o[0] !== 1'b0) begin n_fail++; $display("FAIL prio_ch0_waiting: got %b expected 0", if_p.ok_o[0]); end
      end
      if (cyc == 1) set_ch(0, 32'h0C0, 5'd4); else res_v[0] = 1'b0;
      set_ch(1, 32'h100 + XLEN'(seq), 5'd9);
      acc = if_p.ok_o[1];
      tick();
      if (acc) seq++;
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    set_ch(2, 32'h5, 5'd0);
    tick();
    res_v = '0;
    n_checks++; if (if_p.ok_o[2] !== 1'b1) begin n_fail++; $display("FAIL x0_ok_c2: got %b expected 1", if_p.ok_o[2]); end
    tick();
    n_checks++; if (rv_p !== 1'b0 || rv_r !== 1'b0) begin n_fail++; $display("FAIL x0_rv_c3: got %b/%b expected 0/0", rv_p, rv_r); end
    n_checks++; if (if_p.ok_o !== 3'b111) begin n_fail++; $display("FAIL x0_freed: got %b expected 111", if_p.ok_o); end
    tick();
    n_checks++; if (rv_p !== 1'b0) begin n_fail++; $display("FAIL x0_rv_c4: got %b expected 0", rv_p); end
  endtask

  task automatic test_flush();
    do_reset();
    set_ch(0, 32'd11, 5'd1);
    set_ch(1, 32'd22, 5'd2);
    tick();
    res_v = '0;
    set_ch(2, 32'd33, 5'd3);
    flush = 1'b1;
    #1;
    n_checks++; if (if_p.ok_o !== 3'b000 || if_r.ok_o !== 3'b000) begin n_fail++; $display("FAIL flush_ok: got %b/%b expected 000/000", if_p.ok_o, if_r.ok_o); end
    tick();
    idle_inputs();
    #1;
    n_checks++; if (rv_p !== 1'b0 || rv_r !== 1'b0) begin n_fail++; $display("FAIL flush_rv1: got %b/%b expected 0/0", rv_p, rv_r); end
    n_checks++; if (if_p.ok_o !== 3'b111) begin n_fail++; $display("FAIL flush_empty: got %b expected 111", if_p.ok_o); end
    tick();
    n_checks++; if (rv_p !== 1'b0 || rv_r !== 1'b0) begin n_fail++; $display("FAIL flush_rv2: got %b/%b expected 0/0", rv_p, rv_r); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_ch(0, 32'h1234, 5'd3);
    set_ch(1, 32'h5678, 5'd6);
    tick();
    res_v = '0;
    tick();
    n_checks++; if (rv_p !== 1'b1) begin n_fail++; $display("FAIL areset_pre_rv: got %b expected 1", rv_p); end
    #2 rst_n = 1'b1;
    #1;
    n_checks++; if (rv_p !== 1'b0 || res_p !== '0 || rd_p !== '0) begin
      n_fail++; $display("FAIL areset_out: got v=%b d=%h rd=%0d expected 0 0 0", rv_p, res_p, rd_p);
    end
    n_checks++; if (cc_p !== 16'd0) begin n_fail++; $display("FAIL areset_conflict: got %0d expected 0", cc_p); end
    n_checks++; if (if_p.ok_o !== 3'b111) begin n_fail++; $display("FAIL areset_ok: got %b expected 111", if_p.ok_o); end
    do_reset();
  endtask

  task automatic test_random();
    int w [2];
    bit bp [2];
    logic [NCH-1:0] mok [2];
    logic [NCH-1:0] got_ok;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < NCH; i++) m_bv[n][i] = 1'b0;
      m_rr[n] = 0; m_pr[n] = 0; m_cc[n] = 0; m_rv[n] = 1'b0;
    end
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NCH; i++) begin
        res_v[i] = ($urandom_range(9) < 7);
        res[i*XLEN +: XLEN] = XLEN'($urandom);
        rdi[i*RDW +: RDW] = ($urandom_range(5) == 0) ? '0 : RDW'($urandom_range(31));
      end
      flush = ($urandom_range(15) == 0);
      for (int n = 0; n < 2; n++) begin
        w[n] = model_pick(n, bp[n]);
        for (int i = 0; i < NCH; i++) mok[n][i] = !flush && (!m_bv[n][i] || w[n] == i);
      end
      #1;
      for (int n = 0; n < 2; n++) begin
        got_ok = (n == 0) ? if_p.ok_o : if_r.ok_o;
        n_checks++; if (got_ok !== mok[n]) begin n_fail++; $display("FAIL rand_ok inst%0d t%0d: got %b expected %b", n, t, got_ok, mok[n]); end
      end
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        model_step(n, w[n], bp[n], mok[n]);
        n_checks++; if (((n == 0) ? rv_p : rv_r) !== m_rv[n]) begin
          n_fail++; $display("FAIL rand_rv inst%0d t%0d: got %b expected %b", n, t, (n == 0) ? rv_p : rv_r, m_rv[n]);
        end
        if (m_rv[n]) begin
          n_checks++; if (((n == 0) ? res_p : res_r) !== m_res[n] || ((n == 0) ? rd_p : rd_r) !== m_rd[n]) begin
            n_fail++; $display("FAIL rand_data inst%0d t%0d: got %h/%0d expected %h/%0d", n, t,
                                (n == 0) ? res_p : res_r, (n == 0) ? rd_p : rd_r, m_res[n], m_rd[n]);
          end
        end
        n_checks++; if (((n == 0) ? cc_p : cc_r) !== 16'(m_cc[n])) begin
          n_fail++; $display("FAIL rand_conflict inst%0d t%0d: got %0d expected %0d", n, t, (n == 0) ? cc_p : cc_r, m_cc[n]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_collision();
    test_priority();
    test_x0();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
